// File: rtl/memo_lsu.sv
// Load/store unit in front of the 64x8 byte memory: splits byte/half/word requests into
// single-byte accesses, hides the one-cycle read latency and returns one response per request.
module memo_lsu #(
  parameter int AW   = 6,
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic [AW-1:0]   mem_address,
  output logic [7:0]      mem_data,
  output logic            mem_wren,
  input  logic [7:0]      mem_q,
  output logic [1:0]      dbg_state
);

  // Request handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE. Responses are a
  // single-cycle resp_valid strobe with no backpressure.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e          state_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      idx_q;
  logic [1:0]      last_q;
  logic [XLEN-1:0] buf_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic [AW-1:0]   mem_address_q;
  logic [7:0]      mem_data_q;
  logic            mem_wren_q;

  logic            req_bad_d;
  logic [1:0]      req_last_d;
  logic [1:0]      idx_nxt_d;
  logic [1:0]      idx_prev_d;
  logic [XLEN-1:0] word_d;
  logic [XLEN-1:0] rdata_d;

  always_comb begin
    req_bad_d  = (req_size == 2'd3) ||
                 ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
    req_last_d = (req_size == 2'd0) ? 2'd0 : (req_size == 2'd1) ? 2'd1 : 2'd3;
    idx_nxt_d  = idx_q + 2'd1;
    idx_prev_d = idx_q - 2'd1;
    // The final byte arrives on mem_q during WAIT, so merge it in before extending.
    word_d = buf_q;
    word_d[{last_q, 3'b000} +: 8] = mem_q;
    case (size_q)
      2'd0:    rdata_d = uns_q ? {{(XLEN-8){1'b0}}, word_d[7:0]}
                               : {{(XLEN-8){word_d[7]}}, word_d[7:0]};
      2'd1:    rdata_d = uns_q ? {{(XLEN-16){1'b0}}, word_d[15:0]}
                               : {{(XLEN-16){word_d[15]}}, word_d[15:0]};
      default: rdata_d = word_d;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      size_q        <= 2'd0;
      uns_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      idx_q         <= 2'd0;
      last_q        <= 2'd0;
      buf_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_address_q <= '0;
      mem_data_q    <= 8'd0;
      mem_wren_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q  <= 1'b0;
          resp_err_q    <= 1'b0;
          resp_rdata_q  <= '0;
          mem_address_q <= '0;
          mem_data_q    <= 8'd0;
          mem_wren_q    <= 1'b0;
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx_q   <= 2'd0;
            last_q  <= req_last_d;
            buf_q   <= '0;
            if (req_bad_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q       <= S_ACCESS;
              mem_address_q <= req_addr;
              mem_wren_q    <= req_we;
              mem_data_q    <= req_wdata[7:0];
            end
          end
        end
        S_ACCESS: begin
          // mem_q now holds the byte addressed in the previous ACCESS cycle.
          if (!we_q && (idx_q != 2'd0)) begin
            buf_q[{idx_prev_d, 3'b000} +: 8] <= mem_q;
          end
          if (idx_q == last_q) begin
            mem_address_q <= '0;
            mem_data_q    <= 8'd0;
            mem_wren_q    <= 1'b0;
            if (we_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            idx_q         <= idx_nxt_d;
            mem_address_q <= addr_q + AW'(idx_nxt_d);
            mem_data_q    <= wdata_q[{idx_nxt_d, 3'b000} +: 8];
          end
        end
        S_WAIT: begin
          buf_q        <= word_d;
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= rdata_d;
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_memo_lsu.sv
// Bench for memo_lsu: behavioural 64x8 memo model, vector table, scoreboard queue
// and hand-written sequences for errors, reset mid-store and back-to-back requests.
module tb_memo_lsu;

  localparam int LOG = 4096;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [5:0]  req_addr = 6'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q = 8'd0;
  logic [1:0]  dbg_state;

  logic [7:0]  m [0:63];
  logic [5:0]  addr_log [0:LOG-1];
  logic [7:0]  data_log [0:LOG-1];
  logic        wren_log [0:LOG-1];

  logic [32:0] exp_q [$];
  int          iss_q [$];
  int          lat_q [$];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  vec_t vt [0:15];

  memo_lsu #(.AW(6), .XLEN(32)) dut (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q), .dbg_state(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (mem_wren) m[mem_address] <= mem_data;
    mem_q <= m[mem_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int n_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // monitor + scoreboard
  logic [32:0] e;
  int          e_iss;
  int          e_lat;
  always @(negedge clk) begin
    if (cyc < LOG) begin
      addr_log[cyc] = mem_address;
      data_log[cyc] = mem_data;
      wren_log[cyc] = mem_wren;
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e     = exp_q.pop_front();
        e_iss = iss_q.pop_front();
        e_lat = lat_q.pop_front();
        check("resp_err", {63'd0, resp_err}, {63'd0, e[32]});
        check("resp_rdata", {32'd0, resp_rdata}, {32'd0, e[31:0]});
        check("latency", 64'(cyc - e_iss), 64'(e_lat));
      end
    end
  end

  // driver tasks
  task automatic push_exp(input vec_t v, input int c);
    int n;
    n = n_of(v.size);
    exp_q.push_back({v.err, v.rdata});
    iss_q.push_back(c);
    lat_q.push_back(v.err ? 1 : (v.we ? n + 1 : n + 2));
  endtask

  task automatic drive_fields(input vec_t v);
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  task automatic issue(input vec_t v, input bit push, output int c);
    int g;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) check("ready_timeout", 64'd0, 64'd1);
    drive_fields(v);
    req_valid = 1'b1;
    c = cyc;
    if (push) push_exp(v, c);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      iss_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_access(input vec_t v, input int c);
    int n;
    n = n_of(v.size);
    if (v.err) begin
      check("err_no_wren", {63'd0, wren_log[c+1]}, 64'd0);
      check("err_addr_zero", {58'd0, addr_log[c+1]}, 64'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        check("acc_addr", {58'd0, addr_log[c+1+i]}, {58'd0, 6'(v.addr + 6'(i))});
        check("acc_wren", {63'd0, wren_log[c+1+i]}, {63'd0, v.we});
        if (v.we) check("acc_data", {56'd0, data_log[c+1+i]}, {56'd0, v.wdata[8*i +: 8]});
      end
      check("post_wren", {63'd0, wren_log[c+1+n]}, 64'd0);
    end
  endtask

  initial begin
    int c;
    vec_t v;
    vec_t bb [0:3];

    m[0] = 8'h00;
    for (int i = 1; i <= 8'h30; i++) m[i] = 8'haa;
    for (int i = 8'h31; i <= 8'h39; i++) m[i] = 8'(8'haa - i);
    for (int i = 8'h3a; i <= 8'h3f; i++) m[i] = 8'hbb;

    //            we    size   uns   addr    wdata          err   rdata
    vt[0]  = '{1'b0, 2'd2, 1'b0, 6'h34, 32'h0,        1'b0, 32'h73747576};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 6'h01, 32'h0,        1'b0, 32'hffffffaa};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 6'h01, 32'h0,        1'b0, 32'h000000aa};
    vt[3]  = '{1'b0, 2'd1, 1'b0, 6'h30, 32'h0,        1'b0, 32'h000079aa};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 6'h3a, 32'h0,        1'b0, 32'hffffbbbb};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 6'h3a, 32'h0,        1'b0, 32'h0000bbbb};
    vt[6]  = '{1'b0, 2'd1, 1'b0, 6'h03, 32'h0,        1'b1, 32'h0};
    vt[7]  = '{1'b0, 2'd3, 1'b0, 6'h04, 32'h0,        1'b1, 32'h0};
    vt[8]  = '{1'b1, 2'd2, 1'b0, 6'h02, 32'h11223344, 1'b1, 32'h0};
    vt[9]  = '{1'b1, 2'd2, 1'b0, 6'h3c, 32'hdeadbeef, 1'b0, 32'h0};
    vt[10] = '{1'b0, 2'd2, 1'b0, 6'h3c, 32'h0,        1'b0, 32'hdeadbeef};
    vt[11] = '{1'b1, 2'd1, 1'b0, 6'h20, 32'hffff1234, 1'b0, 32'h0};
    vt[12] = '{1'b0, 2'd1, 1'b0, 6'h20, 32'h0,        1'b0, 32'h00001234};
    vt[13] = '{1'b1, 2'd0, 1'b0, 6'h21, 32'h00000080, 1'b0, 32'h0};
    vt[14] = '{1'b0, 2'd1, 1'b0, 6'h20, 32'h0,        1'b0, 32'hffff8034};
    vt[15] = '{1'b0, 2'd0, 1'b1, 6'h22, 32'h0,        1'b0, 32'h000000aa};

    // reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_rdata", {32'd0, resp_rdata}, 64'd0);
    check("rst_wren", {63'd0, mem_wren}, 64'd0);
    check("rst_addr", {58'd0, mem_address}, 64'd0);
    check("rst_data", {56'd0, mem_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // vector table
    for (int k = 0; k < 16; k++) begin
      issue(vt[k], 1'b1, c);
      wait_done();
      check_access(vt[k], c);
    end
    for (int a = 2; a <= 5; a++) check("err_store_mem", {56'd0, m[a]}, 64'haa);

    // reset during the third ACCESS cycle of a word store at 0x10
    v = '{1'b1, 2'd2, 1'b0, 6'h10, 32'hcafef00d, 1'b0, 32'h0};
    issue(v, 1'b0, c);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_wren", {63'd0, mem_wren}, 64'd0);
    check("midrst_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_m10", {56'd0, m[6'h10]}, 64'h0d);
    check("midrst_m11", {56'd0, m[6'h11]}, 64'hf0);
    check("midrst_m12", {56'd0, m[6'h12]}, 64'haa);
    check("midrst_m13", {56'd0, m[6'h13]}, 64'haa);
    check("midrst_idle_ready", {63'd0, req_ready}, 64'd1);
    v = '{1'b0, 2'd0, 1'b1, 6'h10, 32'h0, 1'b0, 32'h0000000d};
    issue(v, 1'b1, c);
    wait_done();

    // back-to-back byte loads with req_valid held high
    bb[0] = '{1'b0, 2'd0, 1'b0, 6'h31, 32'h0, 1'b0, 32'h00000079};
    bb[1] = '{1'b0, 2'd0, 1'b1, 6'h38, 32'h0, 1'b0, 32'h00000072};
    bb[2] = '{1'b0, 2'd0, 1'b0, 6'h3a, 32'h0, 1'b0, 32'hffffffbb};
    bb[3] = '{1'b0, 2'd0, 1'b1, 6'h00, 32'h0, 1'b0, 32'h00000000};
    for (int j = 0; j < 4; j++) begin
      int g;
      drive_fields(bb[j]);
      req_valid = 1'b1;
      g = 0;
      while (!req_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!req_ready) check("b2b_ready_timeout", 64'd0, 64'd1);
      push_exp(bb[j], cyc);
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
